// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and constants for the load/store unit: access
//            width encodings, FSM state enum, default data width and small
//            helper functions.
// Config   : MISALIGN_CHECK_EN (used by lsu) enables alignment trapping.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam int XLEN_DEFAULT = 64;

  // One-hot access width encodings
  localparam logic [3:0] WDT8  = 4'b0001;
  localparam logic [3:0] WDT16 = 4'b0010;
  localparam logic [3:0] WDT32 = 4'b0100;
  localparam logic [3:0] WDT64 = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // Any encoding that is not exactly one-hot is handled as a full-width access
  function automatic logic [3:0] norm_wdt(input logic [3:0] wdt);
    case (wdt)
      WDT8, WDT16, WDT32, WDT64: norm_wdt = wdt;
      default:                   norm_wdt = WDT64;
    endcase
  endfunction

  // True when the low address bits are not a multiple of the access size
  function automatic logic is_misaligned(input logic [2:0] lo, input logic [3:0] wdt);
    case (wdt)
      WDT16:   is_misaligned = lo[0];
      WDT32:   is_misaligned = |lo[1:0];
      WDT64:   is_misaligned = |lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Purpose  : Request/response and memory-port bundle of the load/store unit.
//            The slave modport is the LSU side; master is the core/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic            req_unsigned;
  logic [3:0]      req_wdt;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;

  logic            mem_ren;
  logic [XLEN-1:0] mem_raddr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wdt;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_unsigned, req_wdt, req_addr, req_wdata,
    output req_ready,
    input  resp_ready,
    output resp_valid, resp_rdata, resp_misalign,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wdt,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_is_store, req_unsigned, req_wdt, req_addr, req_wdata,
    input  req_ready,
    output resp_ready,
    input  resp_valid, resp_rdata, resp_misalign,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wdt,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ext
// Purpose  : Combinational load-data extension. Narrow loads are sign- or
//            zero-extended from their top bit; full-width data passes through.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [3:0]      wdt_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  // Select the extension bit per width; unsigned loads always extend with 0
  always_comb begin
    data_o = data_i;
    case (wdt_i)
      WDT8:    data_o = {{(XLEN-8){~unsigned_i & data_i[7]}},   data_i[7:0]};
      WDT16:   data_o = {{(XLEN-16){~unsigned_i & data_i[15]}}, data_i[15:0]};
      WDT32:   data_o = {{(XLEN-32){~unsigned_i & data_i[31]}}, data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Single-outstanding load/store unit. Accepts one request, drives
//            a one-cycle memory read or write strobe, waits out the read
//            latency, extends load data and holds the response until taken.
// Config   : MISALIGN_CHECK_EN - when defined, unaligned accesses skip memory
//            and respond immediately with resp_misalign=1.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int RD_LATENCY = 1
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            unsigned_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_misalign_q;
  logic            mem_ren_q;
  logic [XLEN-1:0] mem_raddr_q;
  logic            mem_wen_q;
  logic [XLEN-1:0] mem_waddr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_wdt_q;

  logic [3:0]      w_wdt;
  logic            w_misalign;
  logic [XLEN-1:0] w_ext;

  assign w_wdt = norm_wdt(bus.req_wdt);

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(bus.req_addr[2:0], w_wdt);
`else
  assign w_misalign = 1'b0;
`endif

  // mem_wdt_q is held from accept through WAIT, so it doubles as the extension width
  lsu_ext #(.XLEN(XLEN)) u_ext (
    .data_i     (bus.mem_rdata),
    .wdt_i      (mem_wdt_q),
    .unsigned_i (unsigned_q),
    .data_o     (w_ext)
  );

  // Control FSM with all bus outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 3'd0;
      unsigned_q      <= 1'b0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_misalign_q <= 1'b0;
      mem_ren_q       <= 1'b0;
      mem_raddr_q     <= '0;
      mem_wen_q       <= 1'b0;
      mem_waddr_q     <= '0;
      mem_wdata_q     <= '0;
      mem_wdt_q       <= 4'd0;
    end else begin
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            mem_wdt_q   <= w_wdt;
            unsigned_q  <= bus.req_unsigned;
            if (w_misalign) begin
              state_q         <= S_RESP;
              resp_valid_q    <= 1'b1;
              resp_rdata_q    <= '0;
              resp_misalign_q <= 1'b1;
            end else if (bus.req_is_store) begin
              state_q     <= S_WRITE;
              mem_wen_q   <= 1'b1;
              mem_waddr_q <= bus.req_addr;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q     <= S_READ;
              mem_ren_q   <= 1'b1;
              mem_raddr_q <= bus.req_addr;
            end
          end
        end
        S_READ: begin
          // WAIT leaves when the counter reaches zero, so it lasts RD_LATENCY+1 cycles
          cnt_q   <= 3'(RD_LATENCY);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            resp_rdata_q <= w_ext;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_WRITE: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_misalign_q <= 1'b0;
            req_ready_q     <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_misalign = resp_misalign_q;
  assign bus.mem_ren       = mem_ren_q;
  assign bus.mem_raddr     = mem_raddr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_waddr     = mem_waddr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wdt       = mem_wdt_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu: reset, load extension,
//            store, backpressure, back-to-back, mid-flight reset, alignment.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
  import lsu_pkg::*;

  localparam int XLEN       = 64;
  localparam int RD_LATENCY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  lsu_if #(.XLEN(XLEN)) bus();

  lsu #(.XLEN(XLEN), .RD_LATENCY(RD_LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) tick();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready: req_ready=%b required 1", bus.req_ready);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_unsigned = 0; bus.req_wdt = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0; bus.mem_rdata = 0;
    rst = 1'b1;
    tick();
    tests++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_ren, bus.mem_wen, bus.resp_misalign} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: rdy/rv/ren/wen/mis=%b required 00000",
               {bus.req_ready, bus.resp_valid, bus.mem_ren, bus.mem_wen, bus.resp_misalign});
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", bus.req_ready);
    end
  endtask

  task automatic test_load_ext();
    logic [63:0] addrs [8] = '{64'h80000003, 64'h80000002, 64'h80000004, 64'h80000004,
                               64'h80000008, 64'h80000008, 64'h80000001, 64'h80000006};
    logic [3:0]  wdts  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100,
                               4'b1000, 4'b0011, 4'b0001, 4'b0010};
    logic [3:0]  expw  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b0001, 4'b0010};
    logic        unss  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] mems  [8] = '{64'h80, 64'h8001, 64'h80000000, 64'h80000000,
                               64'h8000000000000001, 64'hFE, 64'hFF, 64'h7FFF};
    logic [63:0] exps  [8] = '{64'hFFFFFFFFFFFFFF80, 64'h0000000000008001,
                               64'hFFFFFFFF80000000, 64'h0000000080000000,
                               64'h8000000000000001, 64'h00000000000000FE,
                               64'h00000000000000FF, 64'h0000000000007FFF};
    for (int i = 0; i < 8; i++) begin
      int   ren_cnt;
      int   lat;
      logic wen_seen;
      logic moved;
      wait_ready();
      bus.req_valid = 1; bus.req_is_store = 0; bus.req_addr = addrs[i];
      bus.req_wdt = wdts[i]; bus.req_unsigned = unss[i]; bus.req_wdata = 64'hDEAD;
      bus.mem_rdata = mems[i]; bus.resp_ready = 0;
      tick();
      bus.req_valid = 0;
      ren_cnt = 0; lat = 0; wen_seen = 0; moved = 0;
      tests++;
      if (bus.mem_wdt !== expw[i]) begin
        fails++;
        $display("FAIL load%0d_wdt: mem_wdt=%b required %b", i, bus.mem_wdt, expw[i]);
      end
      while (bus.resp_valid !== 1'b1 && lat < 20) begin
        if (bus.mem_ren === 1'b1) ren_cnt++;
        if (bus.mem_wen === 1'b1) wen_seen = 1;
        if (bus.mem_raddr !== addrs[i] || bus.mem_wdt !== expw[i]) moved = 1;
        tick();
        lat++;
      end
      tests++;
      if (lat !== RD_LATENCY + 2) begin
        fails++;
        $display("FAIL load%0d_latency: resp_valid at E%0d required E%0d", i, lat, RD_LATENCY + 2);
      end
      tests++;
      if (ren_cnt !== 1 || wen_seen !== 1'b0 || moved !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_membus: ren_cycles=%0d wen=%b addr_moved=%b required 1/0/0",
                 i, ren_cnt, wen_seen, moved);
      end
      tests++;
      if (bus.resp_rdata !== exps[i] || bus.resp_misalign !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_rdata: rdata=%h mis=%b required %h 0",
                 i, bus.resp_rdata, bus.resp_misalign, exps[i]);
      end
      bus.resp_ready = 1;
      tick();
      bus.resp_ready = 0;
      tests++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        fails++;
        $display("FAIL load%0d_handshake: resp_valid=%b req_ready=%b required 0 1",
                 i, bus.resp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_store();
    wait_ready();
    bus.req_valid = 1; bus.req_is_store = 1; bus.req_addr = 64'h80000010;
    bus.req_wdt = WDT8; bus.req_unsigned = 0; bus.req_wdata = 64'hAB; bus.resp_ready = 0;
    tick();
    bus.req_valid = 0;
    tests++;
    if ({bus.mem_wen, bus.mem_ren, bus.resp_valid} !== 3'b100 || bus.mem_waddr !== 64'h80000010 ||
        bus.mem_wdata !== 64'hAB || bus.mem_wdt !== WDT8) begin
      fails++;
      $display("FAIL store_E0: wen/ren/rv=%b waddr=%h wdata=%h wdt=%b required 100 80000010 ab 0001",
               {bus.mem_wen, bus.mem_ren, bus.resp_valid}, bus.mem_waddr, bus.mem_wdata, bus.mem_wdt);
    end
    tick();
    tests++;
    if ({bus.mem_wen, bus.mem_ren, bus.resp_valid} !== 3'b001 || bus.resp_rdata !== 64'h0) begin
      fails++;
      $display("FAIL store_E1: wen/ren/rv=%b rdata=%h required 001 0",
               {bus.mem_wen, bus.mem_ren, bus.resp_valid}, bus.resp_rdata);
    end
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.mem_wen !== 1'b0) begin
      fails++;
      $display("FAIL store_done: req_ready=%b wen=%b required 1 0", bus.req_ready, bus.mem_wen);
    end
  endtask

  task automatic test_backpressure_back_to_back();
    int lat = 0;
    wait_ready();
    bus.req_valid = 1; bus.req_is_store = 0; bus.req_addr = 64'h80000002;
    bus.req_wdt = WDT16; bus.req_unsigned = 1; bus.mem_rdata = 64'h8001; bus.resp_ready = 0;
    tick();
    bus.req_valid = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    // A competing store is offered while the response is stalled
    bus.req_valid = 1; bus.req_is_store = 1; bus.req_addr = 64'h80000020; bus.req_wdata = 64'h55;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if ({bus.resp_valid, bus.req_ready, bus.mem_ren, bus.mem_wen} !== 4'b1000 ||
          bus.resp_rdata !== 64'h8001) begin
        fails++;
        $display("FAIL stall_c%0d: rv/rdy/ren/wen=%b rdata=%h required 1000 8001",
                 c, {bus.resp_valid, bus.req_ready, bus.mem_ren, bus.mem_wen}, bus.resp_rdata);
      end
    end
    bus.req_valid = 0;
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready: req_ready=%b resp_valid=%b required 1 0", bus.req_ready, bus.resp_valid);
    end
    // Issue the next store immediately in the first ready cycle
    bus.req_valid = 1; bus.req_wdt = WDT32;
    tick();
    bus.req_valid = 0;
    tests++;
    if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 64'h80000020 || bus.mem_wdata !== 64'h55) begin
      fails++;
      $display("FAIL b2b_store: wen=%b waddr=%h wdata=%h required 1 80000020 55",
               bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
    end
    tick();
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic rv_seen = 0;
    wait_ready();
    bus.req_valid = 1; bus.req_is_store = 0; bus.req_addr = 64'h80000008;
    bus.req_wdt = WDT64; bus.req_unsigned = 0; bus.mem_rdata = 64'h1234; bus.resp_ready = 0;
    tick();
    bus.req_valid = 0;
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_ren, bus.mem_wen} !== 4'b0 ||
        bus.mem_raddr !== 64'h0 || bus.mem_wdt !== 4'h0 || bus.resp_rdata !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: rdy/rv/ren/wen=%b raddr=%h wdt=%b rdata=%h required all 0",
               {bus.req_ready, bus.resp_valid, bus.mem_ren, bus.mem_wen},
               bus.mem_raddr, bus.mem_wdt, bus.resp_rdata);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_ready: req_ready=%b required 1", bus.req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid === 1'b1 || bus.mem_ren === 1'b1) rv_seen = 1;
      tick();
    end
    tests++;
    if (rv_seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_dropped: response_or_read_seen=%b required 0", rv_seen);
    end
  endtask

  task automatic test_misalign();
    logic ren_seen = 0;
    int   lat = 0;
    wait_ready();
    bus.req_valid = 1; bus.req_is_store = 0; bus.req_addr = 64'h80000002;
    bus.req_wdt = WDT32; bus.req_unsigned = 0; bus.mem_rdata = 64'h77; bus.resp_ready = 0;
    tick();
    bus.req_valid = 0;
`ifdef MISALIGN_CHECK_EN
    if (bus.mem_ren === 1'b1) ren_seen = 1;
    tick();
    if (bus.mem_ren === 1'b1) ren_seen = 1;
    tests++;
    if ({bus.resp_valid, bus.resp_misalign, ren_seen} !== 3'b110 || bus.resp_rdata !== 64'h0) begin
      fails++;
      $display("FAIL misalign_E1: rv/mis/ren=%b rdata=%h required 110 0",
               {bus.resp_valid, bus.resp_misalign, ren_seen}, bus.resp_rdata);
    end
`else
    if (bus.mem_ren === 1'b1) ren_seen = 1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if ({bus.resp_valid, bus.resp_misalign, ren_seen} !== 3'b101 || bus.resp_rdata !== 64'h77) begin
      fails++;
      $display("FAIL unaligned_issue: rv/mis/ren=%b rdata=%h required 101 77",
               {bus.resp_valid, bus.resp_misalign, ren_seen}, bus.resp_rdata);
    end
`endif
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_backpressure_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
